pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter FLUSH_DEPTH, default 2, the number of cycles flush is held after a redirect; legal range 1-7.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port br_valid  input  1  branch resolved this cycle; qualifies br_taken.
REQ-006 SHALL have port br_taken  input  1  taken/not-taken from branch_cond.
REQ-007 SHALL have port br_target  input  32  redirect address.
REQ-008 SHALL have port stall  input  1  hazard stall; blocks sequential advance.
REQ-009 SHALL have port if_ready  input  1  instruction memory accepts the request.
REQ-010 SHALL have port if_req  output  1  fetch request valid.
REQ-011 SHALL have port pc  output  32  current fetch address.
REQ-012 SHALL have port pc_plus4  output  32  pc+4, combinational, for link register.
REQ-013 SHALL have port flush  output  1  kill wrong-path instructions downstream.
REQ-014 SHALL have port misalign  output  1  sticky misaligned-target trap flag.
REQ-015 SHALL have port fetch_cnt  output  32  count of accepted fetches.

Function
REQ-016 SHALL implement FSM states BOOT, RUN, FLUSH, TRAP.
REQ-017 SHALL go BOOT -> RUN unconditionally one cycle after reset release; if_req=0 in BOOT and TRAP, 1 in RUN and FLUSH.
REQ-018 SHALL define fire = if_req & if_ready & ~stall; on fire, with no redirect, pc <= pc+4 and fetch_cnt <= fetch_cnt+1.
REQ-019 SHALL hold pc and keep if_req asserted while fire is low (request stable until accepted).
REQ-020 SHALL treat redirect = br_valid & br_taken & (br_target[1:0]==0) as higher priority than fire: pc <= br_target next cycle regardless of stall/if_ready; fetch_cnt still increments if fire.
REQ-021 SHALL, on redirect, enter FLUSH and load a 3-bit counter with FLUSH_DEPTH; flush=1 while counter nonzero, counter decrements every cycle, including stalled cycles.
REQ-022 SHALL return FLUSH -> RUN on the cycle the counter reaches 0; flush thus is high exactly FLUSH_DEPTH cycles starting the cycle after the redirect.
REQ-023 SHALL, on a redirect arriving during FLUSH, take the new target and reload the counter to FLUSH_DEPTH.
REQ-024 SHALL, when br_valid & br_taken & br_target[1:0]!=0 in RUN or FLUSH, enter TRAP: pc frozen, misalign=1, flush=1, held until reset.
REQ-025 SHALL ignore br_valid with br_taken=0, and ignore br_taken with br_valid=0.
REQ-026 SHALL wrap pc modulo 2^32 (32'hFFFF_FFFC + 4 = 0) and fetch_cnt modulo 2^32.
REQ-027 SHALL ignore all inputs in BOOT and TRAP except rst.

Reset
REQ-028 SHALL on rst=1, asynchronously and at any time (including mid-FLUSH or TRAP): state=BOOT, pc=RESET_PC, if_req=0, flush=0, misalign=0, counter=0, fetch_cnt=0.
REQ-029 SHALL hold reset values while rst=1 and resume with BOOT on the first rising edge after release.

Verification
REQ-030 SHALL cover: release reset, if_ready=1, stall=0 -> BOOT 1 cycle, then pc 0,4,8,C on consecutive cycles, fetch_cnt=4.
REQ-031 SHALL cover: pc=8, if_ready=0 for 3 cycles -> pc stays 8, if_req=1; then if_ready=1 -> pc=C next cycle.
REQ-032 SHALL cover: pc=10, stall=1, br_valid=1, br_taken=1, target=100 -> pc=100 next cycle, flush=1 for exactly 2 cycles, then RUN.
REQ-033 SHALL cover: redirect to 100, then redirect to 200 one cycle later -> pc=200, flush high 3 cycles total.
REQ-034 SHALL cover: taken branch to 102 -> TRAP, misalign=1, flush=1, if_req=0, pc unchanged; assert rst -> all outputs return to reset values immediately.
REQ-035 SHALL cover: RESET_PC=32'hFFFF_FFF8, free running -> pc FFFF_FFF8, FFFF_FFFC, 0000_0000.

Source files
------------

// File: rtl/pc_unit.sv
// Program-counter unit: sequential fetch, branch redirect with timed flush,
// and a sticky trap on misaligned branch targets.
module pc_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned FLUSH_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        br_valid,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        stall,
  input  logic        if_ready,
  output logic        if_req,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        flush,
  output logic        misalign,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_FLUSH,
    S_TRAP
  } state_t;

  localparam logic [2:0] DEPTH = 3'(FLUSH_DEPTH);

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_fetch_cnt;
  logic [2:0]  r_cnt;
  logic        r_if_req;
  logic        r_flush;
  logic        r_misalign;

  logic w_active;
  logic w_fire;
  logic w_taken;
  logic w_redirect;
  logic w_trap;

  // Inputs only matter while fetching; BOOT and TRAP see none of them.
  assign w_active   = (r_state == S_RUN) || (r_state == S_FLUSH);
  assign w_fire     = r_if_req & if_ready & ~stall;
  assign w_taken    = w_active & br_valid & br_taken;
  assign w_redirect = w_taken & (br_target[1:0] == 2'b00);
  assign w_trap     = w_taken & (br_target[1:0] != 2'b00);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_BOOT;
      r_pc        <= RESET_PC;
      r_fetch_cnt <= '0;
      r_cnt       <= '0;
      r_if_req    <= 1'b0;
      r_flush     <= 1'b0;
      r_misalign  <= 1'b0;
    end else begin
      case (r_state)
        S_BOOT: begin
          r_state  <= S_RUN;
          r_if_req <= 1'b1;
        end
        S_RUN, S_FLUSH: begin
          if (w_fire) r_fetch_cnt <= r_fetch_cnt + 32'd1;
          if (w_trap) begin
            r_state    <= S_TRAP;
            r_if_req   <= 1'b0;
            r_flush    <= 1'b1;
            r_misalign <= 1'b1;
            r_cnt      <= '0;
          end else if (w_redirect) begin
            r_state <= S_FLUSH;
            r_pc    <= br_target;
            r_cnt   <= DEPTH;
            r_flush <= 1'b1;
          end else begin
            if (w_fire) r_pc <= r_pc + 32'd4;
            // The flush window shrinks every cycle, stalled or not.
            if (r_cnt > 3'd1) begin
              r_cnt   <= r_cnt - 3'd1;
              r_flush <= 1'b1;
              r_state <= S_FLUSH;
            end else begin
              r_cnt   <= '0;
              r_flush <= 1'b0;
              r_state <= S_RUN;
            end
          end
        end
        S_TRAP: begin
          r_state <= S_TRAP;
        end
      endcase
    end
  end

  assign if_req    = r_if_req;
  assign pc        = r_pc;
  assign pc_plus4  = r_pc + 32'd4;
  assign flush     = r_flush;
  assign misalign  = r_misalign;
  assign fetch_cnt = r_fetch_cnt;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios plus randomized traffic checked
// against a behavioural model of fetch/redirect/flush/trap behaviour.
module tb_pc_unit;

  localparam int          FD      = 2;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        br_valid = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        stall = 1'b0;
  logic        if_ready = 1'b0;

  logic        if_req, flush, misalign;
  logic [31:0] pc, pc_plus4, fetch_cnt;
  logic        w_if_req, w_flush, w_misalign;
  logic [31:0] w_pc, w_pc_plus4, w_fetch_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model: what the fetch unit should present after each edge.
  bit          m_boot;
  bit          m_trap;
  int          m_flush_left;
  logic [31:0] m_pc;
  logic [31:0] m_fetches;

  pc_unit #(.RESET_PC(32'h0), .FLUSH_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .br_valid(br_valid), .br_taken(br_taken),
    .br_target(br_target), .stall(stall), .if_ready(if_ready),
    .if_req(if_req), .pc(pc), .pc_plus4(pc_plus4), .flush(flush),
    .misalign(misalign), .fetch_cnt(fetch_cnt)
  );

  pc_unit #(.RESET_PC(WRAP_PC), .FLUSH_DEPTH(FD)) dut_w (
    .clk(clk), .rst(rst), .br_valid(br_valid), .br_taken(br_taken),
    .br_target(br_target), .stall(stall), .if_ready(if_ready),
    .if_req(w_if_req), .pc(w_pc), .pc_plus4(w_pc_plus4), .flush(w_flush),
    .misalign(w_misalign), .fetch_cnt(w_fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_boot       = 1'b1;
    m_trap       = 1'b0;
    m_flush_left = 0;
    m_pc         = 32'h0;
    m_fetches    = 32'h0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit requesting;
    bit accepted;
    if (m_boot) begin
      m_boot = 1'b0;
      return;
    end
    if (m_trap) return;
    requesting = 1'b1;
    accepted   = requesting && if_ready && !stall;
    if (accepted) m_fetches = m_fetches + 1;
    if (br_valid && br_taken) begin
      if (br_target % 4 != 0) begin
        m_trap = 1'b1;
      end else begin
        m_pc         = br_target;
        m_flush_left = FD;
      end
      return;
    end
    if (accepted) m_pc = m_pc + 4;
    if (m_flush_left > 0) m_flush_left--;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".if_req"},    32'(if_req),    32'(!m_boot && !m_trap));
    check({tag, ".pc"},        pc,             m_pc);
    check({tag, ".pc_plus4"},  pc_plus4,       m_pc + 32'd4);
    check({tag, ".flush"},     32'(flush),     32'(m_trap || m_flush_left > 0));
    check({tag, ".misalign"},  32'(misalign),  32'(m_trap));
    check({tag, ".fetch_cnt"}, fetch_cnt,      m_fetches);
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // Assert reset between edges, confirm it acts at once, hold across an edge, release.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    model_reset();
    check_all({tag, ".async"});
    @(posedge clk);
    #1;
    check_all({tag, ".hold"});
    rst = 1'b0;
    check_all({tag, ".boot"});
  endtask

  task automatic set_in(input bit v, input bit t, input logic [31:0] tgt, input bit s, input bit r);
    br_valid  = v;
    br_taken  = t;
    br_target = tgt;
    stall     = s;
    if_ready  = r;
  endtask

  initial begin
    int          n;
    logic [31:0] held_pc;

    model_reset();
    #2;
    check_all("reset");
    @(posedge clk);
    #1;
    check_all("reset_hold");

    // Boot then free-running fetch.
    rst = 1'b0;
    set_in(0, 0, 32'h0, 0, 1);
    check("boot.if_req", 32'(if_req), 32'h0);
    step("run0");
    check("seq.pc0", pc, 32'h0);
    step("run1");
    check("seq.pc4", pc, 32'h4);
    step("run2");
    check("seq.pc8", pc, 32'h8);
    step("run3");
    check("seq.pcC", pc, 32'hC);
    step("run4");
    check("seq.fetch_cnt", fetch_cnt, 32'd4);
    check("seq.pc10", pc, 32'h10);

    // Stalled redirect still taken; flush for FD cycles.
    set_in(1, 1, 32'h100, 1, 1);
    step("redir");
    check("redir.pc", pc, 32'h100);
    check("redir.flush0", 32'(flush), 32'h1);
    set_in(0, 1, 32'h300, 0, 1);
    step("redir_f1");
    check("redir.flush1", 32'(flush), 32'h1);
    step("redir_f2");
    check("redir.flush_done", 32'(flush), 32'h0);

    // Back-to-back redirects reload the flush window.
    set_in(1, 1, 32'h100, 0, 1);
    step("dbl0");
    set_in(1, 1, 32'h200, 0, 1);
    step("dbl1");
    check("dbl.pc", pc, 32'h200);
    set_in(0, 0, 32'h0, 0, 1);
    n = 2;
    for (int i = 0; i < 5; i++) begin
      step("dbl_tail");
      if (flush) n++;
    end
    check("dbl.flush_cycles", 32'(n), 32'd3);

    // br_valid without taken and taken without valid are ignored.
    set_in(1, 0, 32'h800, 0, 1);
    step("ign_nt");
    set_in(0, 1, 32'h800, 0, 1);
    step("ign_nv");

    // Misaligned taken branch traps and freezes.
    held_pc = pc;
    set_in(1, 1, 32'h102, 0, 0);
    step("trap");
    check("trap.misalign", 32'(misalign), 32'h1);
    check("trap.if_req", 32'(if_req), 32'h0);
    check("trap.pc", pc, held_pc);
    set_in(1, 1, 32'h400, 0, 1);
    step("trap_hold0");
    set_in(0, 0, 32'h0, 0, 1);
    step("trap_hold1");
    check("trap.pc_frozen", pc, held_pc);
    do_reset("trap_rst");
    check("trap_rst.misalign", 32'(misalign), 32'h0);

    // Fetch request held stable while memory is not ready.
    set_in(0, 0, 32'h0, 0, 1);
    step("hold_r0");
    step("hold_r1");
    step("hold_r2");
    check("hold.pc8", pc, 32'h8);
    if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("hold_wait");
      check("hold.pc_stays", pc, 32'h8);
      check("hold.if_req", 32'(if_req), 32'h1);
    end
    if_ready = 1'b1;
    step("hold_go");
    check("hold.pcC", pc, 32'hC);

    // Randomized traffic, including occasional resets and traps.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(63) == 0) begin
        do_reset("rand_rst");
      end else begin
        br_valid  = ($urandom_range(3) == 0);
        br_taken  = 1'($urandom_range(1));
        br_target = {$urandom_range(32'h3FFF_FFFF), 2'b00};
        if ($urandom_range(15) == 0) br_target[1:0] = 2'($urandom_range(1, 3));
        stall    = ($urandom_range(3) == 0);
        if_ready = ($urandom_range(3) != 0);
        step("rand");
      end
    end

    // Wraparound from the top of the address space.
    set_in(0, 0, 32'h0, 0, 1);
    do_reset("wrap_rst");
    check("wrap.boot_pc", w_pc, 32'hFFFF_FFF8);
    step("wrap0");
    check("wrap.pc0", w_pc, 32'hFFFF_FFF8);
    step("wrap1");
    check("wrap.pc1", w_pc, 32'hFFFF_FFFC);
    check("wrap.pc_plus4", w_pc_plus4, 32'h0);
    step("wrap2");
    check("wrap.pc2", w_pc, 32'h0);
    check("wrap.fetch_cnt", w_fetch_cnt, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
